// File: rtl/id_ex_elastic_reg_if.sv
// Beat channel between decode and execute: valid/ready handshake plus ID/EX payload.
interface id_ex_elastic_reg_if #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_ADDR_W = 3,
  parameter int unsigned CTRL_W     = 10
);
  logic                  valid;
  logic                  ready;
  logic [DATA_W-1:0]     pc;
  logic [DATA_W-1:0]     rd1;
  logic [DATA_W-1:0]     rd2;
  logic [DATA_W-1:0]     imm;
  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic [REG_ADDR_W-1:0] rd;
  logic [CTRL_W-1:0]     ctrl;

  // Producer side: drives the beat, observes back-pressure.
  modport master (
    output valid, pc, rd1, rd2, imm, rs, rt, rd, ctrl,
    input  ready
  );

  // Consumer side: observes the beat, drives back-pressure.
  modport slave (
    input  valid, pc, rd1, rd2, imm, rs, rt, rd, ctrl,
    output ready
  );
endinterface

// File: rtl/id_ex_elastic_reg.sv
// ID/EX elastic pipeline register: two-entry (main + skid) buffer updated on the
// falling clock edge, with cache-miss hold (hit), branch flush, and a saturating
// stall counter. Optional feature macro IDEX_WB_SNOOP_EN enables write-back snooping
// so held operands stay coherent with the register file while the stage is stalled.
module id_ex_elastic_reg #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned REG_ADDR_W  = 3,
  parameter int unsigned CTRL_W      = 10,
  parameter int unsigned STALL_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hit,
  input  logic                   flush,
  id_ex_elastic_reg_if.slave     in_if,
  id_ex_elastic_reg_if.master    out_if,
  output logic                   skid_full,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  input  logic                   wb_we,
  input  logic [REG_ADDR_W-1:0]  wb_addr,
  input  logic [DATA_W-1:0]      wb_data
);

  // Stage occupancy.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Flat beat layout, LSB first: ctrl, rd, rt, rs, imm, rd2, rd1, pc.
  localparam int unsigned CTRL_LSB = 0;
  localparam int unsigned RD_LSB   = CTRL_LSB + CTRL_W;
  localparam int unsigned RT_LSB   = RD_LSB + REG_ADDR_W;
  localparam int unsigned RS_LSB   = RT_LSB + REG_ADDR_W;
  localparam int unsigned IMM_LSB  = RS_LSB + REG_ADDR_W;
  localparam int unsigned RD2_LSB  = IMM_LSB + DATA_W;
  localparam int unsigned RD1_LSB  = RD2_LSB + DATA_W;
  localparam int unsigned PC_LSB   = RD1_LSB + DATA_W;
  localparam int unsigned BEAT_W   = PC_LSB + DATA_W;

  localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

  logic [1:0]             state_q, state_d;
  logic [BEAT_W-1:0]      main_q, main_d;
  logic [BEAT_W-1:0]      skid_q, skid_d;
  logic                   out_valid_q, out_valid_d;
  logic                   skid_full_q, skid_full_d;
  logic [CTRL_W-1:0]      ctrl_out_q, ctrl_out_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic [BEAT_W-1:0]      in_beat;
  logic [BEAT_W-1:0]      main_s;
  logic [BEAT_W-1:0]      skid_s;
  logic [BEAT_W-1:0]      in_s;

  logic                   in_ready_c;
  logic                   accept_c;
  logic                   drain_c;

  // Handshake qualification on both sides.
  assign in_ready_c = hit & (state_q != ST_FULL) & ~flush;
  assign accept_c   = in_if.valid & in_ready_c;
  assign drain_c    = out_valid_q & out_if.ready & hit;

  assign in_beat = {in_if.pc, in_if.rd1, in_if.rd2, in_if.imm,
                    in_if.rs, in_if.rt, in_if.rd, in_if.ctrl};

`ifdef IDEX_WB_SNOOP_EN
  // Forward a register write into a beat whose source addresses match.
  function automatic logic [BEAT_W-1:0] snoop_beat(
    input logic [BEAT_W-1:0]     b,
    input logic                  we,
    input logic [REG_ADDR_W-1:0] addr,
    input logic [DATA_W-1:0]     data
  );
    logic [BEAT_W-1:0] r;
    r = b;
    if (we && (addr != '0)) begin
      if (b[RS_LSB +: REG_ADDR_W] == addr) r[RD1_LSB +: DATA_W] = data;
      if (b[RT_LSB +: REG_ADDR_W] == addr) r[RD2_LSB +: DATA_W] = data;
    end
    return r;
  endfunction

  // Snooped views of held and incoming beats.
  assign main_s = snoop_beat(main_q,  wb_we, wb_addr, wb_data);
  assign skid_s = snoop_beat(skid_q,  wb_we, wb_addr, wb_data);
  assign in_s   = snoop_beat(in_beat, wb_we, wb_addr, wb_data);
`else
  logic unused_wb;

  // Snoop disabled: beats pass through untouched and the write-back port is a sink.
  assign main_s    = main_q;
  assign skid_s    = skid_q;
  assign in_s      = in_beat;
  assign unused_wb = ^{wb_we, wb_addr, wb_data};
`endif

  // Next-state, payload movement and stall counting.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;

    // Beat held at the output without leaving this edge, for any reason.
    if (out_valid_q && !drain_c && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end

    if (flush) begin
      // Kill everything; clearing ctrl is enough to make the entries harmless.
      state_d                     = ST_EMPTY;
      main_d[CTRL_LSB +: CTRL_W]  = '0;
      skid_d[CTRL_LSB +: CTRL_W]  = '0;
    end else begin
      main_d = main_s;
      skid_d = skid_s;
      if (hit) begin
        case (state_q)
          ST_EMPTY: begin
            if (accept_c) begin
              state_d = ST_ONE;
              main_d  = in_s;
            end
          end
          ST_ONE: begin
            if (drain_c && accept_c) begin
              main_d = in_s;
            end else if (drain_c) begin
              state_d = ST_EMPTY;
            end else if (accept_c) begin
              state_d = ST_FULL;
              skid_d  = in_s;
            end
          end
          ST_FULL: begin
            if (drain_c) begin
              state_d = ST_ONE;
              main_d  = skid_s;
            end
          end
          default: begin
            state_d = ST_EMPTY;
          end
        endcase
      end
    end

    out_valid_d = (state_d != ST_EMPTY);
    skid_full_d = (state_d == ST_FULL);
    ctrl_out_d  = out_valid_d ? main_d[CTRL_LSB +: CTRL_W] : '0;
  end

  // State and payload registers, falling-edge clocked.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
      ctrl_out_q  <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      skid_full_q <= skid_full_d;
      ctrl_out_q  <= ctrl_out_d;
      stall_q     <= stall_d;
    end
  end

  // Output wiring straight from the registers.
  assign in_if.ready  = in_ready_c;
  assign out_if.valid = out_valid_q;
  assign out_if.pc    = main_q[PC_LSB  +: DATA_W];
  assign out_if.rd1   = main_q[RD1_LSB +: DATA_W];
  assign out_if.rd2   = main_q[RD2_LSB +: DATA_W];
  assign out_if.imm   = main_q[IMM_LSB +: DATA_W];
  assign out_if.rs    = main_q[RS_LSB  +: REG_ADDR_W];
  assign out_if.rt    = main_q[RT_LSB  +: REG_ADDR_W];
  assign out_if.rd    = main_q[RD_LSB  +: REG_ADDR_W];
  assign out_if.ctrl  = ctrl_out_q;
  assign skid_full    = skid_full_q;
  assign stall_cnt    = stall_q;

endmodule

// File: doc/id_ex_elastic_reg.md
Name: id_ex_elastic_reg

Overview:
- Parametrised successor to the fixed-width ID/EX pipeline register.
- Two-entry elastic buffer (main + skid) between decode and execute, with valid/ready handshake on both sides.
- Provides cache-miss hold via `hit`, branch flush with bubble insertion, and a saturating stall counter.
- Optional write-back snoop keeps held operands coherent while stalled.

Parameters:
- DATA_W, 16, width of PC, operand and immediate fields
- REG_ADDR_W, 3, register-address width
- CTRL_W, 10, packed control bundle width (RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0], spare)
- STALL_CNT_W, 8, stall counter width

Ports:
- clk  in  1  clock; all state updates on falling edge
- rst_n  in  1  asynchronous active-low reset
- hit  in  1  cache hit; 0 freezes the stage
- flush  in  1  kill all held and incoming entries
- in_valid  in  1  decode beat valid
- in_ready  out  1  stage can accept
- pc_in, rd1_in, rd2_in, imm_in  in  DATA_W each  decode payload
- rs_in, rt_in, rd_in  in  REG_ADDR_W each  register addresses
- ctrl_in  in  CTRL_W  control bundle
- out_valid  out  1  execute beat valid
- out_ready  in  1  execute can take beat
- pc_out, rd1_out, rd2_out, imm_out  out  DATA_W each
- rs_out, rt_out, rd_out  out  REG_ADDR_W each
- ctrl_out  out  CTRL_W  zero whenever out_valid=0
- skid_full  out  1  skid entry occupied
- stall_cnt  out  STALL_CNT_W  saturating held-beat count
- wb_we  in  1; wb_addr  in  REG_ADDR_W; wb_data  in  DATA_W  write-back snoop (used only with the optional feature)

Behaviour:
- Reset (rst_n=0, async): state EMPTY; all payload, ctrl and stall_cnt registers 0; out_valid=0, skid_full=0, ctrl_out=0.
- States: EMPTY (no entry), ONE (main valid), FULL (main + skid valid). out_valid=(state!=EMPTY); skid_full=(state==FULL); both registered.
- in_ready = hit & (state!=FULL) & !flush (combinational).
- Accept = in_valid & in_ready. Drain = out_valid & out_ready & hit.
- Transitions at negedge clk, hit=1, flush=0:
  - EMPTY: accept -> ONE, load main.
  - ONE: drain & accept -> ONE, reload main. Drain only -> EMPTY. Accept only -> FULL, load skid. Neither -> hold.
  - FULL: drain -> ONE, main<=skid. Otherwise hold.
- hit=0: no state or payload change; no transfer on either side.
- flush=1: overrides hit and all handshakes. Next state EMPTY, main/skid ctrl cleared to 0, incoming beat dropped. DATA fields need not be cleared.
- Latency: one falling edge from accept to out_valid when EMPTY. Full throughput when out_ready is held high.
- Payload order is strictly preserved; the skid never overtakes main.
- ctrl_out = out_valid ? main_ctrl : 0, so bubbles cause no register or memory writes.
- stall_cnt increments at each edge where out_valid=1 and drain=0 (including hit=0). It saturates at 2^STALL_CNT_W-1 and is cleared only by reset.
- Async reset mid-transfer discards all entries immediately; release is aligned to clk by the top level.

Optional Feature:
- Macro: IDEX_WB_SNOOP_EN.
- Defined: at every edge with wb_we=1 and wb_addr!=0, any held entry (main or skid) updates its operands:
  - rs==wb_addr -> rd1 <= wb_data.
  - rt==wb_addr -> rd2 <= wb_data.
- A beat accepted on the same edge captures wb_data in place of rd1_in/rd2_in on a match.
- Snoop applies during hit=0. It is suppressed by flush and reset.
- Undefined: wb_* ports are present but ignored; held operands never change.

Test Plan:
- Reset then single beat pc_in=0x0010, ctrl_in=0x041, out_ready=1 -> next falling edge out_valid=1, pc_out=0x0010, ctrl_out=0x041; following edge out_valid=0, ctrl_out=0.
- Back-pressure: out_ready=0, three beats pc=0x20,0x22,0x24 offered -> first two accepted, skid_full=1, in_ready=0. Release out_ready -> outputs 0x20 then 0x22 in order; 0x24 accepted after in_ready rises.
- hit=0 for 5 edges with FULL stage and out_ready=1 -> no transfer, payload unchanged, stall_cnt +5.
- flush asserted with FULL stage and in_valid=1 -> next edge out_valid=0, skid_full=0, ctrl_out=0; no beat emerges.
- stall_cnt saturation: STALL_CNT_W=8, 300 held edges -> stall_cnt=0xFF.
- (IDEX_WB_SNOOP_EN) held main rs=3, rd1=0x1111. wb_we=1, wb_addr=3, wb_data=0xBEEF -> rd1_out=0xBEEF. With wb_addr=0 -> unchanged. Macro off -> unchanged.
